flag_producer: RTL and testbench
================================

FLAG_PRODUCER -- requirements
Module: flag_producer

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low; synchronous deassert is the system's responsibility.
REQ-003 in_valid  input  1  operation request present this cycle.
REQ-004 in_ready  output  1  block can accept a request this cycle.
REQ-005 op  input  2  00 ADD, 01 SUB (a - b), 10 PASS (a only), 11 treated as PASS.
REQ-006 a  input  16  first operand.
REQ-007 b  input  16  second operand; ignored for PASS.
REQ-008 flush  input  1  discard every held entry and block acceptance this cycle.
REQ-009 out_valid  output  1  flags/result hold a valid entry.
REQ-010 out_ready  input  1  consumer takes the entry this cycle.
REQ-011 flags  output  4  {SF,ZF,OF,CF}, bit 3 down to bit 0, in the branch-condition evaluator's encoding.
REQ-012 result  output  16  arithmetic result matching flags.

Function
REQ-013 Accept on in_valid & in_ready; deliver on out_valid & out_ready.
REQ-014 ADD: 17-bit sum a+b; result = sum[15:0]; CF = sum[16].
REQ-015 SUB: a + ~b + 1 in 17 bits; CF = carry-out (1 = no borrow).
REQ-016 PASS: result = a; CF = 0; OF = 0.
REQ-017 ZF = (result == 0); SF = result[15]; OF = signed overflow (operand signs equal, result sign differs; b inverted for SUB).
REQ-018 Latency 1: a request accepted at edge N is presented with out_valid=1 after edge N.
REQ-019 Output entry holds flags and result stable while out_valid=1 and out_ready=0.
REQ-020 Base FSM has two states. EMPTY -> FULL on accept. FULL -> EMPTY on deliver without accept. FULL -> FULL on simultaneous deliver+accept, loading the new entry.
REQ-021 Base in_ready = ~out_valid | out_ready, which is a combinational path from out_ready.
REQ-022 flush: in_ready=0 that cycle; all entries cleared at the edge; out_valid=0 next cycle; a request offered with flush is dropped.
REQ-023 flush has priority over a simultaneous accept and a simultaneous deliver.
REQ-024 Back-to-back ops with out_ready held 1 sustain one result per cycle.

Reset
REQ-025 rst_n=0 immediately forces out_valid=0, flags=4'b0000, result=16'h0000, FSM=EMPTY, and clears the skid entry.
REQ-026 Reset mid-operation discards in-flight entries; the first accept after deassert behaves as in REQ-018.
REQ-027 in_ready=1 in the first cycle after deassert.

Configuration
REQ-028 Macro FLAG_PRODUCER_SKID_EN selects the skid buffer.
- Defined: adds a one-entry skid register; in_ready = ~skid_full (registered, no out_ready path); on a stall, an accepted request parks in the skid and drains to the output when it frees, preserving order; throughput and latency are as REQ-018 and REQ-024.
- Undefined: no skid register; REQ-021 applies.
REQ-029 Flag/result values are identical with and without the macro.

Structure
REQ-030 Shared package flag_pkg holds: op encodings, flag bit indices (SF=3, ZF=2, OF=1, CF=0), data width 16, and the flags struct/typedef.
REQ-031 Combinational arithmetic and flag generation live in sub-module flag_calc (op, a, b -> result, flags); flag_producer holds only the FSM, registers and skid.

Verification
REQ-032 ADD a=16'h7FFF, b=16'h0001 -> next cycle result=16'h8000, flags=4'b1010 (SF, OF).
REQ-033 SUB a=16'h0005, b=16'h0005 -> result=16'h0000, flags=4'b0101 (ZF, CF); SUB a=16'h0003, b=16'h0005 -> result=16'hFFFE, flags=4'b1000.
REQ-034 ADD a=16'hFFFF, b=16'h0001 with out_ready=0 for 3 cycles -> result=16'h0000, flags=4'b0101 held stable; in base build in_ready=0; one deliver on the first out_ready=1.
REQ-035 With FLAG_PRODUCER_SKID_EN, issue 2 requests during a stall -> the second is accepted into the skid, then in_ready=0; after out_ready rises both are delivered in order on consecutive cycles.
REQ-036 flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0; the offered request never appears.
REQ-037 rst_n pulsed low mid-stall -> out_valid and flags drop to 0 asynchronously; after deassert, PASS a=16'h0000 -> flags=4'b0100.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared definitions for the flag producer: op encodings, flag bit positions,
// data width and the registered entry layout.
package flag_pkg;

  localparam int unsigned DATA_W = 16;

  localparam int unsigned SF_BIT = 3;
  localparam int unsigned ZF_BIT = 2;
  localparam int unsigned OF_BIT = 1;
  localparam int unsigned CF_BIT = 0;

  typedef enum logic [1:0] {
    OP_ADD      = 2'b00,
    OP_SUB      = 2'b01,
    OP_PASS     = 2'b10,
    OP_PASS_ALT = 2'b11
  } op_e;

  // Field order matches the {SF,ZF,OF,CF} bit indices above.
  typedef struct packed {
    logic sf;
    logic zf;
    logic of;
    logic cf;
  } flags_t;

  typedef struct packed {
    flags_t              flags;
    logic [DATA_W-1:0]   result;
  } entry_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/flag_calc.sv
// Combinational ADD/SUB/PASS datapath producing result and {SF,ZF,OF,CF}.
module flag_calc
  import flag_pkg::*;
(
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] res;
  logic              arith;
  flags_t            f;

  always_comb begin
    sum   = '0;
    b_eff = '0;
    arith = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        b_eff = b;
        sum   = {1'b0, a} + {1'b0, b};
        arith = 1'b1;
      end
      OP_SUB: begin
        b_eff = ~b;
        sum   = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        arith = 1'b1;
      end
      default: begin
        sum   = {1'b0, a};
        arith = 1'b0;
      end
    endcase
    res  = sum[DATA_W-1:0];
    // Overflow compares a against the effective (possibly inverted) b operand.
    f.cf = arith & sum[DATA_W];
    f.of = arith & (a[DATA_W-1] == b_eff[DATA_W-1]) & (res[DATA_W-1] != a[DATA_W-1]);
    f.zf = (res == '0);
    f.sf = res[DATA_W-1];
  end

  assign result = res;
  assign flags  = f;

endmodule

// File: rtl/flag_producer.sv
// Registered flag/result producer with valid/ready handshakes and flush.
// Define FLAG_PRODUCER_SKID_EN to add a one-entry skid so in_ready is registered.
module flag_producer
  import flag_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  flags,
  output logic [15:0] result
);

  logic [DATA_W-1:0] calc_result;
  logic [3:0]        calc_flags;
  entry_t            calc_entry;

  flag_calc u_calc (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (calc_result),
    .flags  (calc_flags)
  );

  assign calc_entry = entry_t'({calc_flags, calc_result});

  state_e state_q, state_d;
  entry_t out_q, out_d;
  logic   accept;
  logic   deliver;

  assign out_valid = (state_q == ST_FULL);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;
  assign flags     = out_q.flags;
  assign result    = out_q.result;

`ifdef FLAG_PRODUCER_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_full_q, skid_full_d;

  assign in_ready = ~flush & ~skid_full_q;

  // The skid only fills while the output is stalled, so when it is full
  // in_ready is low and a drain never competes with a new accept.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      out_d       = '0;
      skid_d      = '0;
      skid_full_d = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_FULL;
            out_d   = calc_entry;
          end
        end
        ST_FULL: begin
          if (deliver) begin
            if (skid_full_q) begin
              out_d       = skid_q;
              skid_full_d = 1'b0;
            end else if (accept) begin
              out_d = calc_entry;
            end else begin
              state_d = ST_EMPTY;
            end
          end else if (accept) begin
            skid_d      = calc_entry;
            skid_full_d = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q      <= '0;
      skid_full_q <= 1'b0;
    end else begin
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
    end
  end
`else
  assign in_ready = ~flush & (~out_valid | out_ready);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    if (flush) begin
      state_d = ST_EMPTY;
      out_d   = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_FULL;
            out_d   = calc_entry;
          end
        end
        ST_FULL: begin
          if (accept) begin
            out_d = calc_entry;
          end else if (deliver) begin
            state_d = ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_flag_producer.sv
// Self-checking bench for flag_producer: directed vectors plus randomized traffic
// against a queue-based reference model. Honours FLAG_PRODUCER_SKID_EN.
module tb_flag_producer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  flags;
  logic [15:0] result;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [19:0] mq[$];

  flag_producer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flags     (flags),
    .result    (result)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] ref_calc(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    int          ua, ub, sa, sb, r, sr;
    bit          cf, ovf;
    logic [15:0] res;
    ua = x; ub = y;
    sa = $signed(x); sb = $signed(y);
    case (o)
      2'd0: begin r = ua + ub; cf = (r > 65535); sr = sa + sb; ovf = (sr > 32767) || (sr < -32768); end
      2'd1: begin r = ua - ub; cf = (ua >= ub);  sr = sa - sb; ovf = (sr > 32767) || (sr < -32768); end
      default: begin r = ua; cf = 1'b0; ovf = 1'b0; end
    endcase
    res = 16'(r);
    return {res[15], (res == 16'h0000), ovf, cf, res};
  endfunction

  function automatic logic model_ready();
    if (flush) return 1'b0;
`ifdef FLAG_PRODUCER_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || out_ready;
`endif
  endfunction

  task automatic drive(input logic iv, input logic [1:0] o, input logic [15:0] x,
                       input logic [15:0] y, input logic orr, input logic fl);
    in_valid = iv; op = o; a = x; b = y; out_ready = orr; flush = fl;
    #1;
  endtask

  // Advance one clock edge and apply the handshake rules to the model queue.
  task automatic tick();
    bit acc, del;
    logic [19:0] e;
    acc = in_valid && model_ready();
    del = (mq.size() != 0) && out_ready;
    e   = ref_calc(op, a, b);
    @(posedge clk);
    #1;
    if (flush) mq.delete();
    else begin
      if (del) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++;
    if ({flags, result} !== 20'h0) begin n_fail++; $display("FAIL reset_flags_result got=%h exp=00000", {flags, result}); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_vectors();
    drive(1, 2'b00, 16'h7FFF, 16'h0001, 1, 0); tick();
    drive(1, 2'b01, 16'h0005, 16'h0005, 1, 0);
    n_checks++;
    if ({out_valid, flags, result} !== {1'b1, 4'b1010, 16'h8000}) begin
      n_fail++; $display("FAIL add_overflow got=%b/%b/%h exp=1/1010/8000", out_valid, flags, result);
    end
    tick();
    drive(1, 2'b01, 16'h0003, 16'h0005, 1, 0);
    n_checks++;
    if ({out_valid, flags, result} !== {1'b1, 4'b0101, 16'h0000}) begin
      n_fail++; $display("FAIL sub_equal got=%b/%b/%h exp=1/0101/0000", out_valid, flags, result);
    end
    tick();
    drive(0, 2'b00, 16'h0000, 16'h0000, 1, 0);
    n_checks++;
    if ({out_valid, flags, result} !== {1'b1, 4'b1000, 16'hFFFE}) begin
      n_fail++; $display("FAIL sub_borrow got=%b/%b/%h exp=1/1000/fffe", out_valid, flags, result);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL vectors_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_stall();
    drive(1, 2'b00, 16'hFFFF, 16'h0001, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'b00, 16'h0000, 16'h0000, 0, 0);
      n_checks++;
      if ({out_valid, flags, result} !== {1'b1, 4'b0101, 16'h0000}) begin
        n_fail++; $display("FAIL stall_hold[%0d] got=%b/%b/%h exp=1/0101/0000", i, out_valid, flags, result);
      end
      n_checks++;
`ifdef FLAG_PRODUCER_SKID_EN
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_in_ready[%0d] got=%b exp=1", i, in_ready); end
`else
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", i, in_ready); end
`endif
      tick();
    end
    drive(0, 2'b00, 16'h0000, 16'h0000, 1, 0);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release got=%b exp=1", out_valid); end
    tick();
    drive(0, 2'b00, 16'h0000, 16'h0000, 1, 0);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_single_deliver got=%b exp=0", out_valid); end
    tick();
  endtask

`ifdef FLAG_PRODUCER_SKID_EN
  task automatic test_skid();
    drive(1, 2'b00, 16'h0001, 16'h0002, 0, 0); tick();
    drive(1, 2'b01, 16'h0009, 16'h0004, 0, 0);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_accept_second got=%b exp=1", in_ready); end
    tick();
    drive(1, 2'b10, 16'hABCD, 16'h0000, 0, 0);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_full_ready got=%b exp=0", in_ready); end
    tick();
    drive(0, 2'b00, 16'h0000, 16'h0000, 1, 0);
    n_checks++;
    if ({out_valid, flags, result} !== {1'b1, 4'b0000, 16'h0003}) begin
      n_fail++; $display("FAIL skid_first got=%b/%b/%h exp=1/0000/0003", out_valid, flags, result);
    end
    tick();
    drive(0, 2'b00, 16'h0000, 16'h0000, 1, 0);
    n_checks++;
    if ({out_valid, flags, result} !== {1'b1, 4'b0001, 16'h0005}) begin
      n_fail++; $display("FAIL skid_second got=%b/%b/%h exp=1/0001/0005", out_valid, flags, result);
    end
    tick();
    drive(0, 2'b00, 16'h0000, 16'h0000, 1, 0);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_drained got=%b exp=0", out_valid); end
    tick();
  endtask
`endif

  task automatic test_flush();
    drive(1, 2'b10, 16'h1234, 16'h0000, 0, 0); tick();
    drive(1, 2'b00, 16'h1111, 16'h2222, 1, 1);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 2'b00, 16'h0000, 16'h0000, 1, 0);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_cleared[%0d] got=%b exp=0", i, out_valid); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(1, 2'b00, 16'h7FFF, 16'h7FFF, 0, 0); tick();
    drive(0, 2'b00, 16'h0000, 16'h0000, 0, 0); tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, flags, result} !== {1'b1 ^ 1'b1, 4'b0000, 16'h0000}) begin
      n_fail++; $display("FAIL async_reset got=%b/%b/%h exp=0/0000/0000", out_valid, flags, result);
    end
    mq.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 2'b10, 16'h0000, 16'h0000, 1, 0);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got=%b exp=1", in_ready); end
    tick();
    drive(0, 2'b00, 16'h0000, 16'h0000, 1, 0);
    n_checks++;
    if ({out_valid, flags, result} !== {1'b1, 4'b0100, 16'h0000}) begin
      n_fail++; $display("FAIL post_reset_pass got=%b/%b/%h exp=1/0100/0000", out_valid, flags, result);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      drive(1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1, 0);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, in_ready); end
      if (i > 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || mq.size() != 1 || {flags, result} !== mq[0]) begin
          n_fail++; $display("FAIL b2b_out[%0d] got=%b/%h exp=1/%h", i, out_valid, {flags, result}, (mq.size() != 0) ? mq[0] : 20'h0);
        end
      end
      tick();
    end
    drive(0, 2'b00, 16'h0000, 16'h0000, 1, 0); tick();
  endtask

  task automatic test_random();
    logic [15:0] corner[5];
    logic [15:0] x, y;
    corner[0] = 16'h0000; corner[1] = 16'h0001; corner[2] = 16'h7FFF;
    corner[3] = 16'h8000; corner[4] = 16'hFFFF;
    for (int i = 0; i < 400; i++) begin
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), x, y,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
      n_checks++;
      if (out_valid !== (mq.size() != 0)) begin
        n_fail++; $display("FAIL rand_valid[%0d] got=%b exp=%b", i, out_valid, mq.size() != 0);
      end else if (mq.size() != 0) begin
        n_checks++;
        if ({flags, result} !== mq[0]) begin
          n_fail++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, {flags, result}, mq[0]);
        end
      end
      n_checks++;
      if (in_ready !== model_ready()) begin
        n_fail++; $display("FAIL rand_in_ready[%0d] got=%b exp=%b", i, in_ready, model_ready());
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 2'b00, 16'h0000, 16'h0000, 0, 0);
    #6;
    test_reset();
    #5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL first_cycle_ready got=%b exp=1", in_ready); end
    test_vectors();
    test_stall();
`ifdef FLAG_PRODUCER_SKID_EN
    test_skid();
`endif
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
